// File: rtl/dispatch_pkg.sv
// Shared definitions for the dual-core dispatcher: instruction field positions,
// dependency-key extraction helpers and FSM state encodings.
package dispatch_pkg;

  // Instruction field bit positions
  localparam int unsigned PIN_BIT  = 28;  // 1: instruction pinned to a core
  localparam int unsigned CORE_BIT = 27;  // pinned core (0: queue 1, 1: queue 2)
  localparam int unsigned SRC_MEM  = 23;  // source operand is a memory location
  localparam int unsigned DST_MEM  = 22;  // destination operand is a memory location
  localparam int unsigned DST_SEL  = 21;  // selects dest register field [20:16] vs [15:11]
  localparam int unsigned SRC_SEL  = 10;  // selects src register field [9:5] vs [4:0]

  localparam int unsigned KEY_W = 7;
  typedef logic [KEY_W-1:0] key_t;

  // FSM state encodings
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EVAL = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  // Source key: {mem flag, select flag, selected 5-bit register field}
  function automatic key_t src_key(input logic [31:0] instr);
    return {instr[SRC_MEM], instr[SRC_SEL], instr[SRC_SEL] ? instr[9:5] : instr[4:0]};
  endfunction

  // Destination key: {mem flag, select flag, selected 5-bit register field}
  function automatic key_t dst_key(input logic [31:0] instr);
    return {instr[DST_MEM], instr[DST_SEL], instr[DST_SEL] ? instr[20:16] : instr[15:11]};
  endfunction

endpackage

// File: rtl/dual_core_dispatch_queue.sv
// dispatch_queue: DEPTH x IW circular FIFO for one execution core.
// Ports:
//   clk, reset     - clock, synchronous active-high reset
//   i_push/i_push_data - enqueue (ignored when full)
//   i_pop          - dequeue head (ignored when empty)
//   o_valid/o_head - queue non-empty / head entry (0 when empty)
//   o_count/o_full - occupancy / full flag
//   o_occ/o_entries - per-slot occupied mask and raw storage for dependency checks
module dispatch_queue #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned IW    = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_push,
  input  logic [IW-1:0]               i_push_data,
  input  logic                        i_pop,
  output logic                        o_valid,
  output logic [IW-1:0]               o_head,
  output logic [$clog2(DEPTH):0]      o_count,
  output logic                        o_full,
  output logic [DEPTH-1:0]            o_occ,
  output logic [DEPTH-1:0][IW-1:0]    o_entries
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DEPTH-1:0][IW-1:0] r_mem;
  logic [AW-1:0]            r_wptr;
  logic [AW-1:0]            r_rptr;
  logic [CW-1:0]            r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_valid   = (r_count != '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && o_valid;

  // Head is gated so an empty queue presents zero rather than stale storage
  assign o_head    = o_valid ? r_mem[r_rptr] : '0;
  assign o_count   = r_count;
  assign o_entries = r_mem;

  // Slot i is live when its distance from the read pointer is below the count
  always_comb begin
    o_occ = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      o_occ[i] = ({1'b0, AW'(i) - r_rptr} < r_count);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr] <= i_push_data;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/dual_core_dispatch.sv
// dual_core_dispatch: accepts one instruction at a time and steers it into one
// of two per-core queues, honouring pinning, keeping dependent instructions on
// the core that holds their producer/consumer, and otherwise alternating.
// Ports:
//   clk, reset           - clock, synchronous active-high reset
//   in_valid/in_ready/in_instr - upstream handshake (in_ready registered)
//   c1_valid/c1_ready/c1_instr - core 1 queue head handshake
//   c2_valid/c2_ready/c2_instr - core 2 queue head handshake
//   c1_count/c2_count    - queue occupancies
//   dep_stall            - held instruction blocked (dependency or full queue)
module dual_core_dispatch
  import dispatch_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned IW    = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IW-1:0]          in_instr,
  output logic                   c1_valid,
  input  logic                   c1_ready,
  output logic [IW-1:0]          c1_instr,
  output logic                   c2_valid,
  input  logic                   c2_ready,
  output logic [IW-1:0]          c2_instr,
  output logic [$clog2(DEPTH):0] c1_count,
  output logic [$clog2(DEPTH):0] c2_count,
  output logic                   dep_stall
);

  logic [1:0]    r_state;
  logic [1:0]    w_state_d;
  logic [IW-1:0] r_hold;
  logic          r_rr;        // 0: queue 1 next, 1: queue 2 next
  logic          r_in_ready;

  logic                     w_full1, w_full2;
  logic [DEPTH-1:0]         w_occ1, w_occ2;
  logic [DEPTH-1:0][IW-1:0] w_ent1, w_ent2;

  logic w_capture;
  logic w_busy;
  logic w_chk_en;
  key_t w_new_src, w_new_dst;
  logic w_conf1, w_conf2;
  logic w_tgt_ok, w_tgt;
  logic w_push, w_push1, w_push2;

  assign in_ready  = r_in_ready;
  assign dep_stall = (r_state == S_WAIT);
  assign w_capture = (r_state == S_IDLE) && in_valid && r_in_ready;
  assign w_busy    = (r_state == S_EVAL) || (r_state == S_WAIT);

  // Dependency comparison against every live entry of each queue
  assign w_chk_en  = !(r_hold[SRC_MEM] & r_hold[DST_MEM]);
  assign w_new_src = src_key(r_hold[31:0]);
  assign w_new_dst = dst_key(r_hold[31:0]);

  always_comb begin
    w_conf1 = 1'b0;
    w_conf2 = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (w_occ1[i] && ((w_new_src == dst_key(w_ent1[i][31:0])) ||
                        (w_new_dst == src_key(w_ent1[i][31:0])) ||
                        (w_new_dst == dst_key(w_ent1[i][31:0])))) begin
        w_conf1 = 1'b1;
      end
      if (w_occ2[i] && ((w_new_src == dst_key(w_ent2[i][31:0])) ||
                        (w_new_dst == src_key(w_ent2[i][31:0])) ||
                        (w_new_dst == dst_key(w_ent2[i][31:0])))) begin
        w_conf2 = 1'b1;
      end
    end
    if (!w_chk_en) begin
      w_conf1 = 1'b0;
      w_conf2 = 1'b0;
    end
  end

  // Target selection; only the round-robin case may redirect on a full queue
  always_comb begin
    w_tgt_ok = 1'b1;
    w_tgt    = r_rr;
    if (r_hold[PIN_BIT]) begin
      w_tgt = r_hold[CORE_BIT];
    end else if (w_conf1 && !w_conf2) begin
      w_tgt = 1'b0;
    end else if (w_conf2 && !w_conf1) begin
      w_tgt = 1'b1;
    end else if (w_conf1 && w_conf2) begin
      w_tgt_ok = 1'b0;
    end else begin
      if (!r_rr && w_full1 && !w_full2) begin
        w_tgt = 1'b1;
      end else if (r_rr && w_full2 && !w_full1) begin
        w_tgt = 1'b0;
      end
    end
  end

  // Room is judged on start-of-cycle count; a same-cycle pop does not help
  assign w_push  = w_busy && w_tgt_ok && (w_tgt ? !w_full2 : !w_full1);
  assign w_push1 = w_push && !w_tgt;
  assign w_push2 = w_push && w_tgt;

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      S_IDLE:         if (w_capture) w_state_d = S_EVAL;
      S_EVAL, S_WAIT: w_state_d = w_push ? S_IDLE : S_WAIT;
      default:        w_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_hold     <= '0;
      r_rr       <= 1'b0;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_in_ready <= (w_state_d == S_IDLE);
      if (w_capture) begin
        r_hold <= in_instr;
      end
      if (w_push) begin
        r_rr <= !w_tgt;
      end
    end
  end

  dispatch_queue #(
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_q1 (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push1),
    .i_push_data (r_hold),
    .i_pop       (c1_valid && c1_ready),
    .o_valid     (c1_valid),
    .o_head      (c1_instr),
    .o_count     (c1_count),
    .o_full      (w_full1),
    .o_occ       (w_occ1),
    .o_entries   (w_ent1)
  );

  dispatch_queue #(
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_q2 (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push2),
    .i_push_data (r_hold),
    .i_pop       (c2_valid && c2_ready),
    .o_valid     (c2_valid),
    .o_head      (c2_instr),
    .o_count     (c2_count),
    .o_full      (w_full2),
    .o_occ       (w_occ2),
    .o_entries   (w_ent2)
  );

endmodule
